// File: rtl/layer_output_collector_pkg.sv
// Shared fixed-point format and collector state encoding for the layer output collector.
package layer_output_collector_pkg;

   localparam int INTEGER_WIDTH  = 8;
   localparam int FRACTION_WIDTH = 8;

   typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

   typedef enum logic [1:0] {
      COLLECTING = 2'd0,
      PRESENTING = 2'd1,
      HOLDING    = 2'd2
   } collector_state_t;

endpackage

// File: rtl/layer_output_collector_argmax_scanner.sv
// Sequential argmax over the held vector: one element per cycle, strict signed
// greater-than so ties keep the lowest index.
module argmax_scanner
   import layer_output_collector_pkg::*;
#(
   parameter int NUM_NEURONS = 16
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   start,
   input  logic   abort,
   input  fixed_t values [NUM_NEURONS],
   output logic [(NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1)-1:0] argmax,
   output logic   argmax_valid
);

   localparam int INDEX_WIDTH = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   logic [INDEX_WIDTH-1:0] index;
   fixed_t                 best;
   logic                   scanning;

   // Element 0 is consumed in the start cycle, so valid lands NUM_NEURONS cycles later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         index        <= '0;
         best         <= '0;
         scanning     <= 1'b0;
         argmax       <= '0;
         argmax_valid <= 1'b0;
      end else if (abort) begin
         scanning     <= 1'b0;
         argmax_valid <= 1'b0;
      end else if (start) begin
         best         <= values[0];
         argmax       <= '0;
         index        <= INDEX_WIDTH'(1);
         scanning     <= (NUM_NEURONS > 1);
         argmax_valid <= (NUM_NEURONS == 1);
      end else if (scanning) begin
         if (values[index] > best) begin
            best   <= values[index];
            argmax <= index;
         end
         if (index == INDEX_WIDTH'(NUM_NEURONS - 1)) begin
            scanning     <= 1'b0;
            argmax_valid <= 1'b1;
         end
         index <= index + 1'b1;
      end
   end

endmodule

// File: rtl/layer_output_collector.sv
// Collects one output per upstream neuron, presents the full vector with a one-cycle
// pulse and holds it until the next layer finishes. Optional argmax: LAYER_OUTPUT_COLLECTOR_ARGMAX_EN.
module layer_output_collector
   import layer_output_collector_pkg::*;
#(
   parameter int NUM_NEURONS = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  fixed_t                 neuron_outputs [NUM_NEURONS],
   input  logic [NUM_NEURONS-1:0] neuron_outputs_ready,
   output fixed_t                 outputs [NUM_NEURONS],
   output logic                   outputs_ready,
   input  logic                   next_layer_done,
   output logic                   busy,
   output logic                   overrun_error
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
   ,
   output logic [(NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1)-1:0] argmax,
   output logic                   argmax_valid
`endif
);

   collector_state_t       state, state_next;
   logic [NUM_NEURONS-1:0] captured, accepted, dropped;
   logic                   release_vector;

   assign release_vector = (state != COLLECTING) && next_layer_done;
   assign outputs_ready  = (state == PRESENTING);
   assign busy           = (state != COLLECTING);

   // Any pulse not accepted into an empty slot is dropped and flagged.
   always_comb begin
      accepted   = '0;
      dropped    = '0;
      state_next = state;
      case (state)
         COLLECTING: begin
            accepted = neuron_outputs_ready & ~captured;
            dropped  = neuron_outputs_ready & captured;
            if (&(captured | accepted)) state_next = PRESENTING;
         end
         PRESENTING, HOLDING: begin
            dropped    = neuron_outputs_ready;
            state_next = next_layer_done ? COLLECTING : HOLDING;
         end
         default: state_next = COLLECTING;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= COLLECTING;
         captured      <= '0;
         overrun_error <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) outputs[i] <= '0;
      end else begin
         state <= state_next;
         if (|dropped) overrun_error <= 1'b1;
         if (release_vector) captured <= '0;
         else                captured <= captured | accepted;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (accepted[i]) outputs[i] <= neuron_outputs[i];
         end
      end
   end

`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
   argmax_scanner #(
      .NUM_NEURONS (NUM_NEURONS)
   ) u_argmax_scanner (
      .clock        (clock),
      .reset        (reset),
      .start        (state == PRESENTING),
      .abort        (release_vector),
      .values       (outputs),
      .argmax       (argmax),
      .argmax_valid (argmax_valid)
   );
`endif

endmodule

// File: tb/tb_layer_output_collector.sv
// Scoreboard bench for layer_output_collector with a behavioural reference model.
module tb_layer_output_collector;
   import layer_output_collector_pkg::*;

   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset;
   fixed_t       neuron_outputs [N];
   logic [N-1:0] neuron_outputs_ready;
   fixed_t       outputs [N];
   logic         outputs_ready;
   logic         next_layer_done;
   logic         busy;
   logic         overrun_error;
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
   logic [1:0]   argmax;
   logic         argmax_valid;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Reference model: phase 0 = gathering, 1 = vector just completed, 2 = waiting for release
   bit     m_cap [N];
   fixed_t m_out [N];
   bit     m_ovr;
   int     m_phase;
   int     m_age;
   int     m_amax;
   fixed_t exp_q [$];

   layer_output_collector #(
      .NUM_NEURONS (N)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .neuron_outputs       (neuron_outputs),
      .neuron_outputs_ready (neuron_outputs_ready),
      .outputs              (outputs),
      .outputs_ready        (outputs_ready),
      .next_layer_done      (next_layer_done),
      .busy                 (busy),
      .overrun_error        (overrun_error)
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
      ,
      .argmax               (argmax),
      .argmax_valid         (argmax_valid)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cap[i] = 1'b0;
         m_out[i] = '0;
      end
      m_ovr   = 1'b0;
      m_phase = 0;
      m_age   = 0;
      m_amax  = 0;
      exp_q.delete();
   endtask

   task automatic model_edge(input logic [N-1:0] p, input logic d);
      bit     all;
      fixed_t best;
      if (m_phase == 0) begin
         for (int i = 0; i < N; i++) begin
            if (p[i]) begin
               if (m_cap[i]) m_ovr = 1'b1;
               else begin
                  m_cap[i] = 1'b1;
                  m_out[i] = neuron_outputs[i];
               end
            end
         end
         all = 1'b1;
         for (int i = 0; i < N; i++) all &= m_cap[i];
         if (all) begin
            m_phase = 1;
            m_age   = 0;
            for (int i = 0; i < N; i++) exp_q.push_back(m_out[i]);
            best   = m_out[0];
            m_amax = 0;
            for (int i = 1; i < N; i++) begin
               if (m_out[i] > best) begin
                  best   = m_out[i];
                  m_amax = i;
               end
            end
         end
      end else begin
         if (p != '0) m_ovr = 1'b1;
         if (d) begin
            m_phase = 0;
            for (int i = 0; i < N; i++) m_cap[i] = 1'b0;
         end else begin
            m_phase = 2;
            m_age++;
         end
      end
   endtask

   // Inputs are applied 1 time unit after a rising edge and consumed at the next one.
   task automatic step(input logic [N-1:0] p, input logic d);
      neuron_outputs_ready = p;
      next_layer_done      = d;
      @(posedge clock);
      model_edge(p, d);
      #1;
      neuron_outputs_ready = '0;
      next_layer_done      = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_overrun", overrun_error, 1'b0);
      for (int i = 0; i < N; i++) check("reset_outputs", outputs[i], 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic set_vals(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] e);
      neuron_outputs[0] = fixed_t'(a);
      neuron_outputs[1] = fixed_t'(b);
      neuron_outputs[2] = fixed_t'(c);
      neuron_outputs[3] = fixed_t'(e);
   endtask

   function automatic fixed_t rand_val();
      logic [15:0] r;
      r = 16'($urandom);
      if (r[0]) r = {{13{r[3]}}, r[3:1]} << 8;
      return fixed_t'(r);
   endfunction

   task automatic rand_vals();
      for (int i = 0; i < N; i++) neuron_outputs[i] = rand_val();
   endtask

   // Monitor: every falling edge compares the DUT against the model; a presented vector is popped from the scoreboard.
   always @(negedge clock) begin
      check("outputs_ready", outputs_ready, (m_phase == 1));
      check("busy", busy, (m_phase != 0));
      check("overrun_error", overrun_error, m_ovr);
      for (int i = 0; i < N; i++) check("outputs_held", outputs[i], m_out[i]);
      if (outputs_ready) begin
         check("sb_depth", exp_q.size(), N);
         if (exp_q.size() >= N) begin
            for (int i = 0; i < N; i++) check("sb_vector", outputs[i], exp_q.pop_front());
         end
      end
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
      check("argmax_valid", argmax_valid, (m_phase != 0) && (m_age >= N));
      if (argmax_valid) check("argmax", argmax, m_amax);
`endif
   end

   initial begin
      reset                = 1'b0;
      neuron_outputs_ready = '0;
      next_layer_done      = 1'b0;
      set_vals(16'h0, 16'h0, 16'h0, 16'h0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      step('0, 1'b0);

      // Sequential collection
      set_vals(16'h0100, 16'h0280, 16'hFF00, 16'h0040);
      step(4'b0001, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      check("t1_ready_early", outputs_ready, 1'b0);
      step(4'b1000, 1'b0);
      check("t1_ready", outputs_ready, 1'b1);
      check("t1_busy", busy, 1'b1);
      check("t1_out0", outputs[0], fixed_t'(16'h0100));
      check("t1_out1", outputs[1], fixed_t'(16'h0280));
      check("t1_out2", outputs[2], fixed_t'(16'hFF00));
      check("t1_out3", outputs[3], fixed_t'(16'h0040));
      step('0, 1'b0);
      check("t1_ready_once", outputs_ready, 1'b0);
      check("t1_busy_hold", busy, 1'b1);
      step('0, 1'b1);

      // All-simultaneous collection, released straight from the presenting cycle
      rand_vals();
      step(4'b1111, 1'b0);
      check("t2_ready", outputs_ready, 1'b1);
      check("t2_overrun", overrun_error, 1'b0);
      step('0, 1'b1);
      check("t2_released", busy, 1'b0);

      // Duplicate pulse
      set_vals(16'h0000, 16'h0100, 16'h0000, 16'h0000);
      step(4'b0010, 1'b0);
      neuron_outputs[1] = fixed_t'(16'h0500);
      step(4'b0010, 1'b0);
      check("t3_kept", outputs[1], fixed_t'(16'h0100));
      check("t3_overrun", overrun_error, 1'b1);
      rand_vals();
      step(4'b1101, 1'b0);
      step('0, 1'b0);

      // Hold: pulses and input changes are ignored, release-cycle pulse is dropped
      rand_vals();
      step(4'b0001, 1'b0);
      for (int k = 0; k < 20; k++) begin
         rand_vals();
         step('0, 1'b0);
      end
      check("t4_overrun", overrun_error, 1'b1);
      step(4'b0001, 1'b1);
      check("t4_released", busy, 1'b0);
      rand_vals();
      step(4'b1111, 1'b0);
      step('0, 1'b1);

      // Reset mid-collection
      rand_vals();
      step(4'b0011, 1'b0);
      do_reset();
      rand_vals();
      for (int i = 0; i < N; i++) step(4'(1 << i), 1'b0);
      check("t5_ready", outputs_ready, 1'b1);
      step('0, 1'b1);

      // Argmax vector, full scan then early release
      set_vals(16'h0100, 16'h0300, 16'h0300, 16'hF000);
      step(4'b1111, 1'b0);
      repeat (N + 1) step('0, 1'b0);
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
      check("t6_valid", argmax_valid, 1'b1);
      check("t6_argmax", argmax, 2'd1);
`endif
      step('0, 1'b1);
      step(4'b1111, 1'b0);
      step('0, 1'b0);
      step('0, 1'b0);
      step('0, 1'b1);
      repeat (N + 1) step('0, 1'b0);
`ifdef LAYER_OUTPUT_COLLECTOR_ARGMAX_EN
      check("t6_aborted", argmax_valid, 1'b0);
`endif

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] p;
         logic         d;
         rand_vals();
         p = '0;
         d = 1'b0;
         if (m_phase == 0) begin
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
         end else begin
            if ($urandom_range(0, 15) == 0) p = N'($urandom);
            d = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 199) == 0) do_reset();
         else step(p, d);
      end
      step('0, (m_phase != 0));
      step('0, 1'b0);
      check("sb_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
